// File: rtl/spiflash_pkg.sv
// spiflash_pkg: shared types and constants for the SPI flash word reader.
//   state_t      - controller states
//   CMD_*        - flash opcodes
//   *_BITS       - shift lengths for each transaction phase
//   byte_swap32  - turns an MSB-first byte stream into a little-endian word
package spiflash_pkg;

  typedef enum logic [2:0] {
    INIT,
    GAP,
    IDLE,
    CMD,
    ADDR,
    DATA
  } state_t;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_WAKE = 8'hAB;

  localparam int BIT_CNT_W = 6;
  localparam logic [BIT_CNT_W-1:0] CMD_BITS  = 6'd8;
  localparam logic [BIT_CNT_W-1:0] ADDR_BITS = 6'd24;
  localparam logic [BIT_CNT_W-1:0] DATA_BITS = 6'd32;

  // First received byte sits in [31:24] of the shift register; it must land
  // in [7:0] of the response.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spiflash_shifter.sv
// spiflash_shifter: SPI mode-0 bit engine.
//   clk, rst  - system clock, async active-high reset
//   start     - load tx/nbits and begin shifting (also legal on the done cycle,
//               which chains segments without a gap on sck)
//   nbits     - number of bits to shift (1..32)
//   tx        - outgoing bits, left aligned (bit 31 goes first)
//   miso      - serial input, sampled on the edge that raises sck
//   sck, mosi - serial clock / data out; mosi only moves while sck is low
//   busy      - a segment is in progress
//   done      - combinational: the coming clk edge ends the last bit
//   rx        - received bits, first bit ends up in the highest shifted position
module spiflash_shifter
  import spiflash_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIT_CNT_W-1:0] nbits,
  input  logic [31:0]          tx,
  input  logic                 miso,
  output logic                 sck,
  output logic                 mosi,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          rx
);

  logic [7:0]           div_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [31:0]          sreg;
  logic                 div_end;

  assign div_end = (div_cnt == 8'(DIV - 1));
  assign done    = busy & sck & div_end & (bit_cnt == '0);
  assign mosi    = sreg[31];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      sck     <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sreg    <= '0;
      rx      <= '0;
    end else if (start) begin
      // start wins over the final falling edge so back-to-back segments
      // keep an uninterrupted 2*DIV bit cadence
      busy    <= 1'b1;
      sck     <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= nbits - 1'b1;
      sreg    <= tx;
    end else if (busy) begin
      if (div_end) begin
        div_cnt <= '0;
        if (!sck) begin
          sck <= 1'b1;
          rx  <= {rx[30:0], miso};
        end else begin
          sck  <= 1'b0;
          sreg <= {sreg[30:0], 1'b0};
          if (bit_cnt == '0) busy <= 1'b0;
          else bit_cnt <= bit_cnt - 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/spiflash_reader.sv
// spiflash_reader: reads 32-bit little-endian words from a SPI NOR flash
// with the single-bit 0x03 READ command.
//   clk, rst              - system clock, async active-high reset
//   req_valid/ready/addr  - read request; address is forced word aligned
//   resp_valid/resp_data  - one-cycle response pulse; data held until next one
//   sck, csb              - flash clock and chip select (active low)
//   io_o, io_oe, io_i     - pad buffer: io0 = MOSI, io1 = MISO, io2/io3 held 1
// After reset a 0xAB wake-up byte is sent before the first request is taken.
module spiflash_reader
  import spiflash_pkg::*;
#(
  parameter int DIV    = 1,
  parameter int CS_GAP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        sck,
  output logic        csb,
  output logic [3:0]  io_o,
  output logic [3:0]  io_oe,
  input  logic [3:0]  io_i
);

  state_t      state_q, state_d;
  logic        csb_q, csb_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;

  logic                 sh_start;
  logic [BIT_CNT_W-1:0] sh_nbits;
  logic [31:0]          sh_tx;
  logic                 sh_sck, sh_mosi, sh_busy, sh_done;
  logic [31:0]          sh_rx;

  logic unused_io;
  assign unused_io = ^{io_i[3:2], io_i[0]};

  spiflash_shifter #(.DIV(DIV)) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .start (sh_start),
    .nbits (sh_nbits),
    .tx    (sh_tx),
    .miso  (io_i[1]),
    .sck   (sh_sck),
    .mosi  (sh_mosi),
    .busy  (sh_busy),
    .done  (sh_done),
    .rx    (sh_rx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= INIT;
      csb_q        <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      addr_q       <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      csb_q        <= csb_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      addr_q       <= addr_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    csb_d        = csb_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    addr_d       = addr_q;
    gap_cnt_d    = gap_cnt_q;
    sh_start     = 1'b0;
    sh_nbits     = CMD_BITS;
    sh_tx        = '0;
    case (state_q)
      INIT: begin
        // shifter idle here only on the first cycle after reset release
        if (!sh_busy) begin
          sh_start = 1'b1;
          sh_nbits = CMD_BITS;
          sh_tx    = {CMD_WAKE, 24'h0};
          csb_d    = 1'b0;
        end else if (sh_done) begin
          csb_d     = 1'b1;
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == 16'(CS_GAP - 1)) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + 16'd1;
      end
      IDLE: begin
        if (req_valid) begin
          addr_d  = {req_addr[23:2], 2'b00};
          state_d = CMD;
        end
      end
      CMD: begin
        // one setup cycle after acceptance, then csb drops with the first bit
        if (!sh_busy) begin
          sh_start = 1'b1;
          sh_nbits = CMD_BITS;
          sh_tx    = {CMD_READ, 24'h0};
          csb_d    = 1'b0;
        end else if (sh_done) begin
          sh_start = 1'b1;
          sh_nbits = ADDR_BITS;
          sh_tx    = {addr_q, 8'h0};
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (sh_done) begin
          sh_start = 1'b1;
          sh_nbits = DATA_BITS;
          sh_tx    = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (sh_done) begin
          csb_d        = 1'b1;
          resp_valid_d = 1'b1;
          resp_data_d  = byte_swap32(sh_rx);
          gap_cnt_d    = '0;
          state_d      = GAP;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign csb        = csb_q;
  assign sck        = sh_sck;
  // MOSI is forced low whenever the flash is deselected
  assign io_o       = {2'b11, 1'b0, ~csb_q & sh_mosi};
  assign io_oe      = 4'b1101;

endmodule

// File: tb/tb_spiflash_reader.sv
// tb_spiflash_reader: two DUT copies (DIV=1 and DIV=3) each with a behavioural
// flash, a frame scoreboard (csb-low length, bit count, command/address) and a
// response scoreboard (data and cycle of resp_valid).
module tb_spiflash_reader;

  localparam int CSG = 4;

  typedef struct {
    int          nbits;
    logic [31:0] hdr;
    int          low;
    int          gap_min;
  } frame_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } resp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input int d, input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL div%0d %s got %h want %h", d, nm, got, exp);
    end
  endtask

  // flash contents as the byte stream seen from a word address, first byte in [31:24]
  function automatic logic [31:0] flash_word(input logic [23:0] a);
    case (a)
      24'h000104: return 32'h13000000;
      24'h000208: return 32'hA55AC33C;
      default:    return 32'hDEADBEEF;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : blk
    localparam int D = (g == 0) ? 1 : 3;

    logic        rst, req_valid, req_ready, resp_valid, sck, csb, miso;
    logic [23:0] req_addr;
    logic [31:0] resp_data;
    logic [3:0]  io_o, io_oe, io_i;
    bit          fin = 1'b0;

    assign io_i = {2'b11, miso, io_o[0]};

    spiflash_reader #(.DIV(D), .CS_GAP(CSG)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .sck        (sck),
      .csb        (csb),
      .io_o       (io_o),
      .io_oe      (io_oe),
      .io_i       (io_i)
    );

    frame_t frame_q[$];
    resp_t  resp_q[$];

    // ---- behavioural flash: capture MOSI on sck rise, drive MISO on sck fall
    logic [63:0] cap = '0;
    int          bc = 0;
    logic [31:0] stream = '0;
    logic        sck_q = 1'b0;
    initial miso = 1'b0;

    always @(negedge csb or posedge sck or negedge sck) begin
      if (sck !== sck_q) begin
        if (sck) begin
          if (!csb) begin
            cap = {cap[62:0], io_o[0]};
            bc++;
          end
        end else if (!csb && bc >= 32 && bc < 64) begin
          if (bc == 32) stream = flash_word(cap[23:0]);
          miso = stream[63 - bc];
        end
        sck_q = sck;
      end else begin
        bc   = 0;
        cap  = '0;
        miso = 1'b0;
      end
    end

    // ---- frame scoreboard
    logic csb_p = 1'b1;
    int   low_cnt = 0, hi_cnt = 0, gap_seen = 0, rise_cyc = 0;

    always @(negedge clk) begin
      frame_t f;
      if (csb) begin
        if (!csb_p) begin
          rise_cyc = cyc;
          if (rst) begin
            if (frame_q.size() != 0) void'(frame_q.pop_front());
          end else if (frame_q.size() == 0) begin
            check(D, "frame_unexpected", 1, 0);
          end else begin
            f = frame_q.pop_front();
            check(D, "frame_bits", bc, f.nbits);
            check(D, "frame_hdr", (bc == 64) ? cap[63:32] : cap[31:0], f.hdr);
            check(D, "frame_csb_low", low_cnt, f.low);
            check(D, "frame_gap_ok", gap_seen >= f.gap_min, 1);
          end
          hi_cnt = 0;
        end
        hi_cnt++;
      end else begin
        if (csb_p) begin
          gap_seen = hi_cnt;
          low_cnt  = 0;
        end
        low_cnt++;
      end
      csb_p = csb;
    end

    // ---- response scoreboard and protocol watch
    logic [31:0] last_data = '0;
    logic        sck_n = 1'b0, mosi_n = 1'b0;
    int          acc = 0, viol = 0;

    always @(negedge clk) begin
      resp_t r;
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          check(D, "resp_unexpected", 1, 0);
        end else begin
          r = resp_q.pop_front();
          check(D, "resp_data", resp_data, r.data);
          check(D, "resp_cycle", cyc, r.cyc);
        end
      end
      if (rst) last_data = '0;
      if (csb && (io_o[0] || sck)) viol++;
      if (sck_n && sck && io_o[0] !== mosi_n) viol++;
      if (io_oe !== 4'b1101) viol++;
      if (!resp_valid && resp_data !== last_data) viol++;
      if (resp_valid) last_data = resp_data;
      if (req_valid && req_ready) acc++;
      sck_n  = sck;
      mosi_n = io_o[0];
    end

    task automatic wait_ready(input string nm);
      int n;
      n = 0;
      while (!req_ready && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check(D, nm, req_ready, 1);
    endtask

    // ---- stimulus
    initial begin
      logic [23:0] addrs[4];
      logic [23:0] seen[4];
      logic [31:0] words[4];
      int n;
      addrs = '{24'h000104, 24'h000107, 24'h00020A, 24'h000104};
      seen  = '{24'h000104, 24'h000104, 24'h000208, 24'h000104};
      words = '{32'h00000013, 32'h00000013, 32'h3CC35AA5, 32'h0};
      rst = 1'b1;
      req_valid = 1'b0;
      req_addr = '0;
      frame_q.push_back('{8, 32'h000000AB, 16 * D, 0});
      repeat (3) @(negedge clk);
      check(D, "rst_csb", csb, 1);
      check(D, "rst_sck", sck, 0);
      check(D, "rst_io_o", io_o, 4'b1100);
      check(D, "rst_io_oe", io_oe, 4'b1101);
      check(D, "rst_ready", req_ready, 0);
      check(D, "rst_resp_valid", resp_valid, 0);
      check(D, "rst_resp_data", resp_data, 0);
      rst = 1'b0;

      wait_ready("ready_after_wake");
      check(D, "wake_gap_cycles", cyc - rise_cyc, CSG);

      // four requests with req_valid held high throughout
      for (int i = 0; i < 4; i++) begin
        req_addr  = addrs[i];
        req_valid = 1'b1;
        wait_ready("ready_req");
        if (i < 3) resp_q.push_back('{words[i], cyc + 2 + 128 * D});
        frame_q.push_back('{64, {8'h03, seen[i]}, 128 * D, CSG});
        @(negedge clk);
      end
      req_valid = 1'b0;

      // abort the last request in the middle of bit 40
      repeat (1 + 81 * D) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check(D, "abort_csb", csb, 1);
      check(D, "abort_sck", sck, 0);
      check(D, "abort_resp_valid", resp_valid, 0);
      check(D, "abort_ready", req_ready, 0);
      check(D, "abort_resp_data", resp_data, 0);
      repeat (3) @(negedge clk);
      frame_q.push_back('{8, 32'h000000AB, 16 * D, 0});
      rst = 1'b0;

      wait_ready("ready_after_abort");
      req_addr  = 24'h00020B;
      req_valid = 1'b1;
      resp_q.push_back('{32'h3CC35AA5, cyc + 2 + 128 * D});
      frame_q.push_back('{64, {8'h03, 24'h000208}, 128 * D, CSG});
      @(negedge clk);
      req_valid = 1'b0;

      n = 0;
      while ((resp_q.size() != 0 || frame_q.size() != 0) && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check(D, "drain_pending", resp_q.size() + frame_q.size(), 0);
      repeat (10) @(negedge clk);
      check(D, "acceptances", acc, 5);
      check(D, "protocol_violations", viol, 0);
      fin = 1'b1;
    end
  end

  initial begin
    wait (blk[0].fin && blk[1].fin);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spiflash_reader.md
SPIFLASH_READER -- requirements
Module: spiflash_reader

Interface
REQ-001 SHALL have parameter DIV, default 1: SCK half-period in clk cycles, legal range 1..255.
REQ-002 SHALL have parameter CS_GAP, default 4: minimum clk cycles csb held high between transactions.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  read request present.
REQ-006 SHALL have port req_ready  output  1  request accepted on clk edge where valid&ready.
REQ-007 SHALL have port req_addr  input  24  flash byte address, sampled at acceptance.
REQ-008 SHALL have port resp_valid  output  1  one-cycle pulse, resp_data valid.
REQ-009 SHALL have port resp_data  output  32  read word, little-endian.
REQ-010 SHALL have port sck  output  1  SPI clock to flash.
REQ-011 SHALL have port csb  output  1  flash chip select, active low.
REQ-012 SHALL have port io_o  output  4  pad output values for flash io0..io3.
REQ-013 SHALL have port io_oe  output  4  pad output enables; 1 = drive, for bidirectional pad buffer.
REQ-014 SHALL have port io_i  input  4  pad input values.

Function
REQ-015 SHALL operate single-bit SPI mode 0: io0 = MOSI, io1 = MISO, io2/io3 driven 1 (WP#/HOLD# inactive); io_oe fixed 4'b1101.
REQ-016 SHALL use states INIT, GAP, IDLE, CMD, ADDR, DATA.
REQ-017 On reset release SHALL enter INIT, send one byte 0xAB (release power-down) with csb low, then go to GAP.
REQ-018 GAP SHALL hold csb high, sck low for exactly CS_GAP cycles, then go to IDLE.
REQ-019 req_ready SHALL be 1 only in IDLE; accepting a request at edge N SHALL latch {req_addr[23:2],2'b00} and enter CMD.
REQ-020 csb SHALL fall at edge N+1 and remain low for exactly 64*2*DIV cycles.
REQ-021 Each bit SHALL occupy 2*DIV cycles: sck low first DIV, high second DIV; MOSI changes only while sck low; MISO sampled on the edge raising sck.
REQ-022 CMD SHALL shift 0x03 MSB first (8 bits), ADDR SHALL shift the 24-bit address MSB first, DATA SHALL receive 32 bits.
REQ-023 Received bytes SHALL assemble little-endian: first byte -> resp_data[7:0], fourth -> [31:24]; each byte MSB first.
REQ-024 At edge N+1+128*DIV csb SHALL rise, sck SHALL be low, resp_valid SHALL pulse one cycle with the final word, state SHALL go to GAP.
REQ-025 resp_data SHALL hold its value until next resp_valid.
REQ-026 req_valid while not IDLE SHALL be ignored (no acceptance, no loss of in-flight transaction).
REQ-027 Bit and divider counters SHALL wrap only at defined boundaries; DIV=1 SHALL give sck = clk/2.
REQ-028 io_o[0] SHALL be 0 whenever csb is high.

Reset
REQ-029 On rst: csb=1, sck=0, io_o=4'b1100, io_oe=4'b1101, req_ready=0, resp_valid=0, resp_data=0, state=INIT.
REQ-030 rst asserted mid-transaction SHALL abort immediately to reset values; no resp_valid for the aborted request; INIT repeats after release.

Structure
REQ-031 Package spiflash_pkg SHALL hold state enum, command constants (CMD_READ=0x03, CMD_WAKE=0xAB), bit-count widths.
REQ-032 Sub-module spiflash_shifter SHALL implement divider, sck generation and 8/24/32-bit shift with done strobe; FSM in spiflash_reader.

Verification
REQ-033 Reset release, DIV=1: csb low 16 cycles carrying 0xAB, then high >=4 cycles before req_ready=1.
REQ-034 Request addr 0x000104, flash bytes 0x13,0x00,0x00,0x00 -> MOSI 0x03,0x00,0x01,0x04; resp_data=0x00000013 at acceptance+129 cycles.
REQ-035 Request addr 0x000107 -> flash sees address 0x000104.
REQ-036 DIV=3, back-to-back requests -> csb low 384 cycles each, >=4-cycle gap, two resp_valid pulses, correct data.
REQ-037 rst asserted at bit 40 -> csb=1, sck=0 next edge async, no resp_valid, INIT re-sent.
REQ-038 req_valid held during transaction -> exactly one acceptance per IDLE visit.
